// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Imported by the IF/ID register and the fetch stage top.
package fetch_stage_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_target(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, hold keeps the
// whole bundle, otherwise a bubble is inserted.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               hold_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end else if (!hold_i) begin
      // no new word this cycle: keep contents, mark as bubble
      valid_q <= 1'b0;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, redirect
// with drain of an outstanding request, and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fa_q, fa_d;
  logic [INSTR_W-1:0] skid_q, skid_d;

  logic               ld, fl, hd;
  logic [INSTR_W-1:0] ld_instr;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  tgt;

  assign seq_pc = fa_q + PC_STEP;
  assign tgt    = align_target(br_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      fa_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fa_q    <= fa_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fa_d     = fa_q;
    skid_d   = skid_q;
    ld       = 1'b0;
    fl       = 1'b0;
    hd       = 1'b0;
    ld_instr = imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (freeze) begin
          hd = 1'b1;
          if (imem_ack) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (br_taken) begin
          pc_d = tgt;
          fl   = 1'b1;
          if (imem_ack) fa_d = tgt;
          else          state_d = DROP;
        end else if (imem_ack) begin
          ld   = 1'b1;
          pc_d = seq_pc;
          fa_d = seq_pc;
        end
      end
      HOLD: begin
        if (freeze) begin
          hd = 1'b1;
        end else if (br_taken) begin
          pc_d    = tgt;
          fa_d    = tgt;
          fl      = 1'b1;
          skid_d  = NOP_INSTR;
          state_d = FETCH;
        end else begin
          ld       = 1'b1;
          ld_instr = skid_q;
          pc_d     = seq_pc;
          fa_d     = seq_pc;
          state_d  = FETCH;
        end
      end
      DROP: begin
        // request to the old address must complete before redirect
        if (br_taken) pc_d = tgt;
        if (imem_ack) begin
          fa_d    = pc_d;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = fa_q;

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .flush_i (fl),
    .hold_i  (hd),
    .pc_i    (seq_pc),
    .instr_i (ld_instr),
    .pc_o    (if_pc),
    .instr_o (if_instr),
    .valid_o (if_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, latency sequences and
// a second instance with a reset PC near the top of memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;

  logic        fr1 = 1'b0, bt1 = 1'b0;
  logic [31:0] ba1 = '0;
  logic        req1, ack1, v1;
  logic [31:0] addr1, pc1, in1;

  logic        fr2 = 1'b0, bt2 = 1'b0;
  logic [31:0] ba2 = '0;
  logic        req2, ack2, v2;
  logic [31:0] addr2, pc2, in2;

  int lat = 0;
  int wcnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ack1 = req1 && (wcnt >= lat);
  assign ack2 = req2;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (!req1 || ack1) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(fr1),
    .br_taken(bt1), .br_addr(ba1),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(addr1),
    .if_pc(pc1), .if_instr(in1), .if_valid(v1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .freeze(fr2),
    .br_taken(bt2), .br_addr(ba2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(addr2),
    .if_pc(pc2), .if_instr(in2), .if_valid(v2)
  );

  typedef struct {
    logic        d;
    logic        v;
    logic [31:0] pc;
    logic [31:0] in;
    logic        req;
    logic [31:0] addr;
  } obs_t;

  typedef struct {
    logic        fr;
    logic        bt;
    logic [31:0] ba;
    obs_t        e;
  } vec_t;

  obs_t sbq[$];
  vec_t tbl[15];

  function automatic obs_t o(logic d, logic v,
    logic [31:0] pc, logic [31:0] in,
    logic req, logic [31:0] addr);
    obs_t r;
    r.d = d; r.v = v; r.pc = pc; r.in = in;
    r.req = req; r.addr = addr;
    return r;
  endfunction

  function automatic vec_t mk(logic fr, logic bt,
    logic [31:0] ba, obs_t e);
    vec_t r;
    r.fr = fr; r.bt = bt; r.ba = ba; r.e = e;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
    logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h @%0t",
        nm, act, exp, $time);
    end
  endtask

  task automatic cmp(bit d2, obs_t e);
    obs_t a;
    a = d2 ? o(1'b1, v2, pc2, in2, req2, addr2)
           : o(1'b1, v1, pc1, in1, req1, addr1);
    chk("if_valid", {31'b0, a.v}, {31'b0, e.v});
    chk("imem_req", {31'b0, a.req}, {31'b0, e.req});
    chk("imem_addr", a.addr, e.addr);
    if (e.d) begin
      chk("if_pc", a.pc, e.pc);
      chk("if_instr", a.in, e.in);
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(bit d2, logic fr, logic bt,
    logic [31:0] ba, obs_t e);
    obs_t x;
    if (d2) begin fr2 = fr; bt2 = bt; ba2 = ba; end
    else    begin fr1 = fr; bt1 = bt; ba1 = ba; end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    cmp(d2, x);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0,     o(1, 1, 32'h4,   32'h0,   1, 32'h4));
    tbl[1]  = mk(0, 0, 0,     o(1, 1, 32'h8,   32'h4,   1, 32'h8));
    tbl[2]  = mk(1, 0, 0,     o(1, 1, 32'h8,   32'h4,   0, 32'h8));
    tbl[3]  = mk(1, 0, 0,     o(1, 1, 32'h8,   32'h4,   0, 32'h8));
    tbl[4]  = mk(1, 0, 0,     o(1, 1, 32'h8,   32'h4,   0, 32'h8));
    tbl[5]  = mk(0, 0, 0,     o(1, 1, 32'hC,   32'h8,   1, 32'hC));
    tbl[6]  = mk(0, 0, 0,     o(1, 1, 32'h10,  32'hC,   1, 32'h10));
    tbl[7]  = mk(0, 1, 'h40,  o(1, 0, 32'h0,   32'h0,   1, 32'h40));
    tbl[8]  = mk(0, 0, 0,     o(1, 1, 32'h44,  32'h40,  1, 32'h44));
    tbl[9]  = mk(1, 1, 'h80,  o(1, 1, 32'h44,  32'h40,  0, 32'h44));
    tbl[10] = mk(1, 1, 'h80,  o(1, 1, 32'h44,  32'h40,  0, 32'h44));
    tbl[11] = mk(0, 0, 0,     o(1, 1, 32'h48,  32'h44,  1, 32'h48));
    tbl[12] = mk(1, 0, 0,     o(1, 1, 32'h48,  32'h44,  0, 32'h48));
    tbl[13] = mk(0, 1, 'h103, o(1, 0, 32'h0,   32'h0,   1, 32'h100));
    tbl[14] = mk(0, 0, 0,     o(1, 1, 32'h104, 32'h100, 1, 32'h104));

    #12;
    cmp(1'b0, o(1, 0, 32'h0, 32'h0, 0, 32'h0));
    cmp(1'b1, o(1, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFF8));

    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp(1'b0, o(1, 0, 32'h0, 32'h0, 1, 32'h0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step(1'b0, tbl[i].fr, tbl[i].bt,
      tbl[i].ba, tbl[i].e);

    // redirect to 0x10, then a slow fetch pending at redirect
    step(0, 0, 1, 'h10, o(1, 0, 0, 0, 1, 32'h10));
    lat = 3;
    step(0, 0, 1, 'h80, o(1, 0, 0, 0, 1, 32'h10));
    step(0, 0, 0, 0,    o(1, 0, 0, 0, 1, 32'h10));
    step(0, 1, 0, 0,    o(1, 0, 0, 0, 1, 32'h10));
    step(0, 0, 0, 0,    o(1, 0, 0, 0, 1, 32'h80));
    lat = 0;
    step(0, 0, 0, 0, o(1, 1, 32'h84, 32'h80, 1, 32'h84));

    // one-wait memory: valid pulses per ack, frozen level held
    lat = 1;
    step(0, 0, 0, 0, o(0, 0, 0, 0, 1, 32'h84));
    step(0, 0, 0, 0, o(1, 1, 32'h88, 32'h84, 1, 32'h88));
    step(0, 1, 0, 0, o(1, 1, 32'h88, 32'h84, 1, 32'h88));
    step(0, 0, 0, 0, o(1, 1, 32'h8C, 32'h88, 1, 32'h8C));

    // second redirect while draining overrides the first
    lat = 2;
    step(0, 0, 1, 'h200, o(1, 0, 0, 0, 1, 32'h8C));
    step(0, 0, 1, 'h300, o(1, 0, 0, 0, 1, 32'h8C));
    step(0, 0, 0, 0,     o(1, 0, 0, 0, 1, 32'h300));
    lat = 0;
    step(0, 0, 0, 0, o(1, 1, 32'h304, 32'h300, 1, 32'h304));

    // wrap-around instance
    rst2 = 1'b0;
    #1;
    cmp(1'b1, o(1, 0, 0, 0, 1, 32'hFFFF_FFF8));
    step(1, 0, 0, 0,
      o(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC));
    step(1, 0, 0, 0,
      o(1, 1, 32'h0, 32'hFFFF_FFFC, 1, 32'h0));
    step(1, 0, 0, 0, o(1, 1, 32'h4, 32'h0, 1, 32'h4));
    step(1, 0, 1, 'h23, o(1, 0, 0, 0, 1, 32'h20));
    step(1, 0, 0, 0, o(1, 1, 32'h24, 32'h20, 1, 32'h24));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues instruction-memory requests over a req/ack handshake, and drives the IF/ID pipeline register. It consumes the taken-branch decision and target from the ID-stage condition-check/branch-address logic and the freeze from the hazard unit. A taken branch redirects the PC and flushes IF/ID. A fetch still outstanding at redirect time is drained and its data discarded.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  in  1  stage clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  hazard stall; holds PC and IF/ID.
- br_taken  in  1  branch/jump taken, from ID condition check.
- br_addr  in  32  branch/jump target, from ID.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and ack not yet seen.
- imem_ack  in  1  response valid this cycle; may be asserted in the first request cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- if_pc  out  32  PC+4 of the instruction in IF/ID.
- if_instr  out  32  instruction in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.

## Operation
- Reset (async): pc=RESET_PC, fetch_addr=RESET_PC, state=FETCH, imem_req=0, if_pc=0, if_instr=0 (NOP), if_valid=0, skid buffer cleared.
  - imem_req rises in the first cycle after rst deasserts.
- Priority: freeze > br_taken > normal advance. br_taken is ignored while freeze=1 because its operands may not be ready.
- FETCH: imem_req=1, imem_addr=fetch_addr.
  - ack, no freeze, no br_taken: IF/ID <= {fetch_addr+4, imem_rdata, 1}; pc and fetch_addr <= fetch_addr+4; stay in FETCH.
  - ack with freeze=1: capture imem_rdata into the skid buffer; IF/ID and pc hold; go to HOLD.
  - No ack, freeze=1: all registers hold; request stays up.
  - br_taken, freeze=0: pc <= {br_addr[31:2],2'b00}; IF/ID flushed to {0, NOP, 0}.
    - If ack is seen this cycle: discard the data, fetch_addr <= new pc, stay in FETCH.
    - Otherwise: go to DROP.
- HOLD: imem_req=0.
  - freeze=0, no br_taken: IF/ID <= {fetch_addr+4, skid, 1}; pc and fetch_addr advance by 4; go to FETCH.
  - freeze=0, br_taken: redirect and flush as above; drop the skid contents; go to FETCH.
- DROP: imem_req=1 with the old fetch_addr (a request is never cancelled). freeze is ignored here; the IF/ID register already holds a flushed NOP.
  - A further br_taken overwrites pc.
  - On ack: discard the data, fetch_addr <= pc, go to FETCH.
- Arithmetic: PC increments by 4 mod 2^32, so 32'hFFFF_FFFC wraps to 0. Target low two bits are forced to 0.
- Reset mid-handshake: state returns to the reset values immediately. A pending response is not tracked; memory must also be reset by rst.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle into IF/ID, 1-cycle fetch latency from pc to if_instr.
- Taken-branch penalty: exactly one flushed slot. The target instruction appears in IF/ID 2 cycles after the br_taken cycle with zero-wait memory.
- N-wait memory: if_valid=1 for one cycle per ack, otherwise 0 unless frozen. A frozen IF/ID holds its value and if_valid level.
- imem_addr changes only in a cycle after an ack, or after a redirect while no request is outstanding.

## Structure
- Shared pipeline package:
  - fetch state enum (FETCH, HOLD, DROP);
  - NOP_INSTR = 32'h0;
  - INSTR_W/ADDR_W = 32;
  - PC_STEP = 4.
- Sub-module if_id_reg: registers {pc, instr, valid} with load, flush and hold inputs. Flush has priority over load; hold applies otherwise. Async rst clears it to {0, NOP, 0}.
- FSM, pc, fetch_addr and skid buffer live in fetch_stage.

## Test plan
- Reset then zero-wait memory returning addr-as-data: if_pc=4,8,12 with if_instr=0,4,8 on consecutive cycles; if_valid=1 from the 2nd cycle after reset release.
- freeze=1 for 3 cycles while ack arrives for addr 8: imem_req=0 in HOLD, IF/ID holds the addr-4 instruction. After release if_instr=8 and the next imem_addr=12.
- br_taken with br_addr=32'h40 while ack=1: next cycle if_valid=0 and if_instr=0, imem_addr=0x40; then if_instr=mem[0x40] and if_pc=0x44.
- br_taken with br_addr=0x80 while a 3-cycle-latency fetch of 0x10 is pending: imem_addr stays 0x10 until ack. The data is discarded (if_valid stays 0), then imem_addr=0x80.
- br_taken=1 together with freeze=1: no redirect; pc and IF/ID unchanged.
- RESET_PC=32'hFFFF_FFF8: fetches at FFFF_FFF8, FFFF_FFFC, then 0; br_addr=0x23 fetches 0x20.
